// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared states, watchdog width and control-bus encodings for pipeline_ctrl
package pipeline_ctrl_pkg;

  localparam int WD_W = 16;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } ctrlState_t;

  typedef struct packed {
    logic pcHold;
    logic ifIdHold;
    logic idExHold;
    logic exMemHold;
    logic memWbBubble;
    logic pcRedirect;
    logic ifIdFlush;
    logic idExFlush;
  } ctrlBus_t;

  // Canned control patterns for the three pipeline actions
  localparam ctrlBus_t CTRL_FREEZE = '{pcHold: 1'b1, ifIdHold: 1'b1, idExHold: 1'b1, exMemHold: 1'b1,
                                       memWbBubble: 1'b1, pcRedirect: 1'b0, ifIdFlush: 1'b0, idExFlush: 1'b0};
  localparam ctrlBus_t CTRL_BRANCH = '{pcHold: 1'b0, ifIdHold: 1'b0, idExHold: 1'b0, exMemHold: 1'b0,
                                       memWbBubble: 1'b0, pcRedirect: 1'b1, ifIdFlush: 1'b1, idExFlush: 1'b1};
  localparam ctrlBus_t CTRL_LDUSE  = '{pcHold: 1'b1, ifIdHold: 1'b1, idExHold: 1'b0, exMemHold: 1'b0,
                                       memWbBubble: 1'b0, pcRedirect: 1'b0, ifIdFlush: 1'b0, idExFlush: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - saturating up-counter used for the performance counters
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush scheduler for the five-stage miniRV pipeline
// Mealy controls from RUN/MEM_WAIT state, memory-wait watchdog and saturating event counters.
module pipeline_ctrl #(
  parameter int CNT_W  = 32,
  parameter int MEM_TO = 255
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             load_use,
  input  logic             br_taken_ex,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic             mem_wb_bubble,
  output logic             pc_redirect,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);
  import pipeline_ctrl_pkg::*;

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TO - 1);

  ctrlState_t      state;
  ctrlState_t      stateNext;
  logic [WD_W-1:0] waitCnt;
  logic            memTimeoutQ;
  logic            wdExpire;
  logic            freeze;
  logic            freezeAct;
  logic            brAct;
  logic            luAct;
  ctrlBus_t        ctrl;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state       <= ST_RUN;
      waitCnt     <= '0;
      memTimeoutQ <= 1'b0;
    end else begin
      state   <= stateNext;
      // Held at zero in RUN so every MEM_WAIT episode starts counting from 0
      waitCnt <= (state == ST_MEM_WAIT) ? waitCnt + WD_W'(1) : '0;
      if (wdExpire) begin
        memTimeoutQ <= 1'b1;
      end
    end
  end

  always_comb begin
    stateNext = state;
    freeze    = 1'b0;
    wdExpire  = 1'b0;
    freezeAct = 1'b0;
    brAct     = 1'b0;
    luAct     = 1'b0;
    ctrl      = '0;

    case (state)
      ST_RUN: begin
        freeze = mem_req && !mem_ack;
        if (freeze) begin
          stateNext = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        // An ack in the final watchdog cycle wins, so the timeout flag stays clear
        wdExpire = (waitCnt == WD_LAST) && !mem_ack;
        freeze   = !mem_ack && !wdExpire;
        if (!freeze) begin
          stateNext = ST_RUN;
        end
      end
      default: stateNext = ST_RUN;
    endcase

    if (!cpu_rst) begin
      freezeAct = freeze;
      brAct     = !freeze && br_taken_ex;
      luAct     = !freeze && !br_taken_ex && load_use;
    end

    if (freezeAct) begin
      ctrl = CTRL_FREEZE;
    end else if (brAct) begin
      ctrl = CTRL_BRANCH;
    end else if (luAct) begin
      ctrl = CTRL_LDUSE;
    end
  end

  assign pc_hold       = ctrl.pcHold;
  assign if_id_hold    = ctrl.ifIdHold;
  assign if_id_flush   = ctrl.ifIdFlush;
  assign id_ex_hold    = ctrl.idExHold;
  assign id_ex_flush   = ctrl.idExFlush;
  assign ex_mem_hold   = ctrl.exMemHold;
  assign mem_wb_bubble = ctrl.memWbBubble;
  assign pc_redirect   = ctrl.pcRedirect;
  assign mem_timeout   = memTimeoutQ;

  sat_counter #(.W(CNT_W)) uLuStallCnt (
    .clk (cpu_clk),
    .rst (cpu_rst),
    .inc (luAct),
    .q   (lu_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk (cpu_clk),
    .rst (cpu_rst),
    .inc (brAct),
    .q   (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) uMemWaitCnt (
    .clk (cpu_clk),
    .rst (cpu_rst),
    .inc (freezeAct),
    .q   (mem_wait_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;

  localparam int CNT_W  = 3;
  localparam int MEM_TO = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  // {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_bubble, pc_redirect, if_id_flush, id_ex_flush}
  localparam logic [7:0] FRZ_V = 8'b1111_1000;
  localparam logic [7:0] BR_V  = 8'b0000_0111;
  localparam logic [7:0] LU_V  = 8'b1100_0001;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  logic load_use = 1'b0;
  logic br_taken_ex = 1'b0;
  logic mem_req = 1'b0;
  logic mem_ack = 1'b0;
  logic pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
  logic ex_mem_hold, mem_wb_bubble, pc_redirect, mem_timeout;
  logic [CNT_W-1:0] lu_stall_cnt, flush_cnt, mem_wait_cnt;

  int checks = 0;
  int errors = 0;

  bit mWaiting = 1'b0;
  int mWaitLen = 0;
  int mLu = 0;
  int mFl = 0;
  int mMw = 0;
  bit mTo = 1'b0;

  logic [7:0] ctrlVec;
  assign ctrlVec = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_bubble,
                    pc_redirect, if_id_flush, id_ex_flush};

  pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TO(MEM_TO)) dut (
    .cpu_clk       (cpu_clk),
    .cpu_rst       (cpu_rst),
    .load_use      (load_use),
    .br_taken_ex   (br_taken_ex),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .pc_hold       (pc_hold),
    .if_id_hold    (if_id_hold),
    .if_id_flush   (if_id_flush),
    .id_ex_hold    (id_ex_hold),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_hold   (ex_mem_hold),
    .mem_wb_bubble (mem_wb_bubble),
    .pc_redirect   (pc_redirect),
    .mem_timeout   (mem_timeout),
    .lu_stall_cnt  (lu_stall_cnt),
    .flush_cnt     (flush_cnt),
    .mem_wait_cnt  (mem_wait_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic int satInc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Expected controls for the current cycle: freeze > branch > load-use, all zero in reset
  function automatic logic [7:0] expCtrl();
    bit expire, frz;
    expire = mWaiting && (mWaitLen == MEM_TO - 1) && !mem_ack;
    frz    = mWaiting ? (!mem_ack && !expire) : (mem_req && !mem_ack);
    if (cpu_rst) return 8'h00;
    if (frz) return FRZ_V;
    if (br_taken_ex) return BR_V;
    if (load_use) return LU_V;
    return 8'h00;
  endfunction

  task automatic modelEdge();
    logic [7:0] e;
    e = expCtrl();
    if (cpu_rst) begin
      mWaiting = 1'b0; mWaitLen = 0; mLu = 0; mFl = 0; mMw = 0; mTo = 1'b0;
    end else begin
      if (e == FRZ_V) mMw = satInc(mMw);
      else if (e == BR_V) mFl = satInc(mFl);
      else if (e == LU_V) mLu = satInc(mLu);
      if (mWaiting) begin
        if (mem_ack) mWaiting = 1'b0;
        else if (mWaitLen == MEM_TO - 1) begin mWaiting = 1'b0; mTo = 1'b1; end
        else mWaitLen++;
      end else if (mem_req && !mem_ack) begin
        mWaiting = 1'b1;
        mWaitLen = 0;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit lu, input bit br, input bit rq, input bit ak);
    cpu_rst = r; load_use = lu; br_taken_ex = br; mem_req = rq; mem_ack = ak;
    @(negedge cpu_clk);
  endtask

  task automatic tick();
    modelEdge();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic doReset();
    cycle(1, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 1, 0);
    checks++;
    if (ctrlVec !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %b want %b", ctrlVec, 8'h00); end
    tick();
    checks++;
    if ({lu_stall_cnt, flush_cnt, mem_wait_cnt, mem_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_state got lu=%0d fl=%0d mw=%0d to=%b want all 0", lu_stall_cnt, flush_cnt, mem_wait_cnt, mem_timeout);
    end
  endtask

  task automatic test_load_use();
    doReset();
    cycle(0, 1, 0, 0, 0);
    checks++;
    if (ctrlVec !== LU_V) begin errors++; $display("FAIL load_use_ctrl got %b want %b", ctrlVec, LU_V); end
    tick();
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (ctrlVec !== 8'h00) begin errors++; $display("FAIL load_use_release got %b want %b", ctrlVec, 8'h00); end
    tick();
    checks++;
    if (lu_stall_cnt !== 3'd1) begin errors++; $display("FAIL load_use_cnt got %0d want 1", lu_stall_cnt); end
  endtask

  task automatic test_branch_load_use();
    doReset();
    cycle(0, 1, 1, 0, 0);
    checks++;
    if (ctrlVec !== BR_V) begin errors++; $display("FAIL branch_lu_ctrl got %b want %b", ctrlVec, BR_V); end
    tick();
    checks++;
    if (flush_cnt !== 3'd1 || lu_stall_cnt !== 3'd0) begin
      errors++; $display("FAIL branch_lu_cnt got fl=%0d lu=%0d want fl=1 lu=0", flush_cnt, lu_stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    doReset();
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1, 0);
      checks++;
      if (ctrlVec !== FRZ_V) begin errors++; $display("FAIL mem_wait_freeze[%0d] got %b want %b", i, ctrlVec, FRZ_V); end
      tick();
    end
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (ctrlVec !== 8'h00) begin errors++; $display("FAIL mem_wait_release got %b want %b", ctrlVec, 8'h00); end
    tick();
    checks++;
    if (mem_wait_cnt !== 3'd4) begin errors++; $display("FAIL mem_wait_cnt got %0d want 4", mem_wait_cnt); end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (ctrlVec !== 8'h00) begin errors++; $display("FAIL mem_wait_back_to_run got %b want %b", ctrlVec, 8'h00); end
    tick();
  endtask

  task automatic test_watchdog();
    doReset();
    for (int i = 0; i < MEM_TO; i++) begin
      cycle(0, 0, 0, 1, 0);
      checks++;
      if (ctrlVec !== FRZ_V) begin errors++; $display("FAIL wd_freeze[%0d] got %b want %b", i, ctrlVec, FRZ_V); end
      tick();
    end
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (ctrlVec !== BR_V) begin errors++; $display("FAIL wd_release got %b want %b", ctrlVec, BR_V); end
    tick();
    checks++;
    if (mem_timeout !== 1'b1 || mem_wait_cnt !== 3'(CMAX)) begin
      errors++; $display("FAIL wd_timeout got to=%b mw=%0d want to=1 mw=%0d", mem_timeout, mem_wait_cnt, CMAX);
    end
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (ctrlVec !== 8'h00) begin errors++; $display("FAIL wd_next_access got %b want %b", ctrlVec, 8'h00); end
    tick();
    checks++;
    if (mem_timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b want 1", mem_timeout); end
  endtask

  task automatic test_expire_with_ack();
    doReset();
    for (int i = 0; i < MEM_TO; i++) begin
      cycle(0, 0, 0, 1, 0);
      tick();
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (ctrlVec !== 8'h00) begin errors++; $display("FAIL expire_ack_ctrl got %b want %b", ctrlVec, 8'h00); end
    tick();
    checks++;
    if (mem_timeout !== 1'b0) begin errors++; $display("FAIL expire_ack_timeout got %b want 0", mem_timeout); end
  endtask

  task automatic test_ack_branch();
    doReset();
    cycle(0, 0, 0, 1, 0); tick();
    cycle(0, 0, 0, 1, 0); tick();
    cycle(0, 1, 1, 1, 1);
    checks++;
    if (ctrlVec !== BR_V) begin errors++; $display("FAIL ack_branch_ctrl got %b want %b", ctrlVec, BR_V); end
    tick();
    checks++;
    if (flush_cnt !== 3'd1 || mem_wait_cnt !== 3'd2) begin
      errors++; $display("FAIL ack_branch_cnt got fl=%0d mw=%0d want fl=1 mw=2", flush_cnt, mem_wait_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    doReset();
    cycle(0, 1, 0, 1, 0); tick();
    cycle(0, 0, 0, 1, 0); tick();
    cycle(1, 1, 1, 1, 0);
    checks++;
    if (ctrlVec !== 8'h00) begin errors++; $display("FAIL rst_mid_wait_ctrl got %b want %b", ctrlVec, 8'h00); end
    tick();
    checks++;
    if ({lu_stall_cnt, flush_cnt, mem_wait_cnt, mem_timeout} !== '0) begin
      errors++; $display("FAIL rst_mid_wait_cnt got lu=%0d fl=%0d mw=%0d to=%b want all 0", lu_stall_cnt, flush_cnt, mem_wait_cnt, mem_timeout);
    end
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (ctrlVec !== 8'h00) begin errors++; $display("FAIL rst_mid_wait_access got %b want %b", ctrlVec, 8'h00); end
    tick();
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (ctrlVec !== 8'h00) begin errors++; $display("FAIL rst_mid_wait_run got %b want %b", ctrlVec, 8'h00); end
    tick();
  endtask

  task automatic test_back_to_back();
    doReset();
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1, 1);
      checks++;
      if (ctrlVec !== expCtrl()) begin errors++; $display("FAIL b2b_ctrl[%0d] got %b want %b", i, ctrlVec, expCtrl()); end
      tick();
    end
    checks++;
    if (mem_wait_cnt !== 3'd0) begin errors++; $display("FAIL b2b_wait_cnt got %0d want 0", mem_wait_cnt); end
  endtask

  task automatic test_saturation();
    doReset();
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 0, 0);
      checks++;
      if (ctrlVec !== LU_V) begin errors++; $display("FAIL sat_ctrl[%0d] got %b want %b", i, ctrlVec, LU_V); end
      tick();
    end
    checks++;
    if (lu_stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_cnt got %0d want 7", lu_stall_cnt); end
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(59) == 0), ($urandom_range(3) == 0), ($urandom_range(4) == 0),
            ($urandom_range(2) == 0), ($urandom_range(5) == 0));
      checks++;
      if (ctrlVec !== expCtrl()) begin errors++; $display("FAIL rand_ctrl[%0d] got %b want %b", i, ctrlVec, expCtrl()); end
      tick();
      checks++;
      if ({lu_stall_cnt, flush_cnt, mem_wait_cnt, mem_timeout} !==
          {mLu[CNT_W-1:0], mFl[CNT_W-1:0], mMw[CNT_W-1:0], mTo}) begin
        errors++;
        $display("FAIL rand_state[%0d] got lu=%0d fl=%0d mw=%0d to=%b want lu=%0d fl=%0d mw=%0d to=%b",
                 i, lu_stall_cnt, flush_cnt, mem_wait_cnt, mem_timeout, mLu, mFl, mMw, mTo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_watchdog();
    test_expire_with_ack();
    test_ack_branch();
    test_reset_mid_wait();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
